// File: rtl/cmos_pat_pkg.sv
// Shared types and constants for the CMOS test-pattern stream source.
// Holds FSM/mode enums, colour-bar table and the CRC-16/CCITT-FALSE byte step.
package cmos_pat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_HBLANK = 3'd3,
        ST_ACTIVE = 3'd4,
        ST_VFRONT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CONST   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    // RGB565: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [15:0] BAR_COLOUR [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/cmos_pat_pixel.sv
// Combinational RGB565 pixel generator for the selected test pattern.
// Position inputs come from the timing FSM; no dividers, bar index is supplied directly.
module cmos_pat_pixel
    import cmos_pat_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  mode_t            mode_i,
    input  logic [2:0]       bar_i,
    input  logic [X_W-1:0]   x_i,
    input  logic [Y_W-1:0]   y_i,
    input  logic [15:0]      cnt_i,
    input  logic [15:0]      const_i,
    output logic [15:0]      pixel_o
);

    logic [X_W-1:0] x_cell;
    logic [Y_W-1:0] y_cell;

    assign x_cell = x_i >> 3;
    assign y_cell = y_i >> 3;

    always_comb begin
        pixel_o = 16'h0000;
        case (mode_i)
            MODE_COUNTER: pixel_o = cnt_i;
            MODE_BARS:    pixel_o = BAR_COLOUR[bar_i];
            MODE_CONST:   pixel_o = const_i;
            MODE_CHECKER: pixel_o = (x_cell[0] ^ y_cell[0]) ? 16'hFFFF : 16'h0000;
            default:      pixel_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/cmos_pattern_gen.sv
// OV-style vsync/href/byte-serial RGB565 frame source with selectable test patterns.
// Define CMOS_PAT_CRC_EN to add a per-frame CRC-16/CCITT-FALSE over active bytes on crc_o.
module cmos_pattern_gen
    import cmos_pat_pkg::*;
#(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          H_BLANK   = 100,
    parameter int          VSYNC_LEN = 1000,
    parameter int          V_BACK    = 200,
    parameter int          V_FRONT   = 200,
    parameter logic [15:0] CNT_MAX   = 16'd799
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        enable_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] const_i,
    output logic        cmos_vsyn,
    output logic        cmos_href,
    output logic [7:0]  cmos_data,
    output logic [15:0] frame_cnt_o,
    output logic        frame_done_o
`ifdef CMOS_PAT_CRC_EN
    ,
    output logic [15:0] crc_o
`endif
);

    // state     | meaning
    // ST_IDLE   | outputs quiet, waiting for enable_i
    // ST_VSYNC  | vsyn high for VSYNC_LEN cycles, pattern settings latched on entry
    // ST_VBACK  | V_BACK quiet cycles after vsync
    // ST_HBLANK | H_BLANK href-low cycles before each line
    // ST_ACTIVE | href high, 2*H_ACTIVE bytes, high byte first
    // ST_VFRONT | V_FRONT quiet cycles, then next frame or idle

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int X_W   = $clog2(H_ACTIVE + 1);
    localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int T_A   = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int T_B   = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int T_C   = (T_A > T_B) ? T_A : T_B;
    localparam int T_MAX = (T_C > 2 * H_ACTIVE) ? T_C : 2 * H_ACTIVE;
    localparam int TMR_W = $clog2(T_MAX + 1);

    state_t            state_q;
    logic [TMR_W-1:0]  tmr_q;
    mode_t             mode_q;
    logic [15:0]       const_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic              hi_q;
    logic [2:0]        bar_q;
    logic [BW_W-1:0]   bar_left_q;
    logic [15:0]       pcnt_q;
    logic              vsyn_q;
    logic              href_q;
    logic [7:0]        data_q;
    logic [15:0]       fcnt_q;
    logic              fdone_q;

    logic              tmr_zero;
    logic              last_line;
    logic              start_frame_d;
    logic              load_byte_d;
    logic              frame_end_d;
    logic [15:0]       pixel_d;
    logic [7:0]        byte_d;
    logic [X_W-1:0]    x_d;
    logic              hi_d;
    logic [2:0]        bar_d;
    logic [BW_W-1:0]   bar_left_d;
    logic [15:0]       pcnt_d;

    cmos_pat_pixel #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_pixel (
        .mode_i  (mode_q),
        .bar_i   (bar_q),
        .x_i     (x_q),
        .y_i     (y_q),
        .cnt_i   (pcnt_q),
        .const_i (const_q),
        .pixel_o (pixel_d)
    );

    assign tmr_zero      = (tmr_q == '0);
    assign last_line     = (y_q == Y_W'(V_ACTIVE - 1));
    assign start_frame_d = enable_i && ((state_q == ST_IDLE) || (state_q == ST_VFRONT && tmr_zero));
    assign load_byte_d   = (state_q == ST_HBLANK && tmr_zero) || (state_q == ST_ACTIVE && !tmr_zero);
    assign frame_end_d   = (state_q == ST_ACTIVE) && tmr_zero && last_line;
    assign byte_d        = hi_q ? pixel_d[15:8] : pixel_d[7:0];

    // Position registers point at the byte to be emitted next; they advance after each load.
    always_comb begin
        hi_d       = ~hi_q;
        x_d        = x_q;
        bar_d      = bar_q;
        bar_left_d = bar_left_q;
        pcnt_d     = pcnt_q;
        if (!hi_q) begin
            x_d    = x_q + 1'b1;
            pcnt_d = (pcnt_q == CNT_MAX) ? 16'd0 : pcnt_q + 16'd1;
            if (bar_left_q == '0) begin
                bar_left_d = BW_W'(BAR_W - 1);
                bar_d      = bar_q + 3'd1;
            end else begin
                bar_left_d = bar_left_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            mode_q     <= MODE_COUNTER;
            const_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hi_q       <= 1'b1;
            bar_q      <= '0;
            bar_left_q <= BW_W'(BAR_W - 1);
            pcnt_q     <= '0;
            vsyn_q     <= 1'b0;
            href_q     <= 1'b0;
            data_q     <= '0;
            fcnt_q     <= '0;
            fdone_q    <= 1'b0;
        end else begin
            fdone_q <= 1'b0;
            if (start_frame_d) begin
                state_q <= ST_VSYNC;
                tmr_q   <= TMR_W'(VSYNC_LEN - 1);
                vsyn_q  <= 1'b1;
                mode_q  <= mode_t'(mode_i);
                const_q <= const_i;
                y_q     <= '0;
                pcnt_q  <= '0;
            end else begin
                if (load_byte_d) begin
                    data_q     <= byte_d;
                    hi_q       <= hi_d;
                    x_q        <= x_d;
                    bar_q      <= bar_d;
                    bar_left_q <= bar_left_d;
                    pcnt_q     <= pcnt_d;
                end
                case (state_q)
                    ST_IDLE: begin
                        tmr_q <= '0;
                    end
                    ST_VSYNC: begin
                        if (tmr_zero) begin
                            state_q <= ST_VBACK;
                            tmr_q   <= TMR_W'(V_BACK - 1);
                            vsyn_q  <= 1'b0;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    ST_VBACK: begin
                        if (tmr_zero) begin
                            state_q <= ST_HBLANK;
                            tmr_q   <= TMR_W'(H_BLANK - 1);
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    ST_HBLANK: begin
                        if (tmr_zero) begin
                            state_q <= ST_ACTIVE;
                            tmr_q   <= TMR_W'(2 * H_ACTIVE - 1);
                            href_q  <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (tmr_zero) begin
                            href_q     <= 1'b0;
                            data_q     <= '0;
                            x_q        <= '0;
                            hi_q       <= 1'b1;
                            bar_q      <= '0;
                            bar_left_q <= BW_W'(BAR_W - 1);
                            if (frame_end_d) begin
                                state_q <= ST_VFRONT;
                                tmr_q   <= TMR_W'(V_FRONT - 1);
                                fdone_q <= 1'b1;
                                fcnt_q  <= fcnt_q + 16'd1;
                            end else begin
                                state_q <= ST_HBLANK;
                                tmr_q   <= TMR_W'(H_BLANK - 1);
                                y_q     <= y_q + 1'b1;
                            end
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    ST_VFRONT: begin
                        if (tmr_zero) begin
                            state_q <= ST_IDLE;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmos_vsyn    = vsyn_q;
    assign cmos_href    = href_q;
    assign cmos_data    = data_q;
    assign frame_cnt_o  = fcnt_q;
    assign frame_done_o = fdone_q;

`ifdef CMOS_PAT_CRC_EN
    logic [15:0] crc_run_q;
    logic [15:0] crc_q;

    // The final byte is folded in when loaded, so crc_run_q is complete at the frame-end edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            crc_run_q <= CRC_INIT;
            crc_q     <= '0;
        end else begin
            if (start_frame_d) begin
                crc_run_q <= CRC_INIT;
            end else if (load_byte_d) begin
                crc_run_q <= crc16_byte(crc_run_q, byte_d);
            end
            if (frame_end_d) begin
                crc_q <= crc_run_q;
            end
        end
    end

    assign crc_o = crc_q;
`endif

endmodule
